if_id_pipe_reg: RTL and testbench

IF/ID pipeline register for the 5-stage pipelined CPU. It sits directly downstream of the program counter and instruction memory. It captures the fetched instruction and its PC+4 each cycle and presents them to the decode stage. It supports load-use stalls (hold) and branch flushes (bubble insertion), and keeps saturating stall and flush event counters for performance debug.

---
 rtl/if_id_pipe_reg_pkg.sv | 14 +
 rtl/if_id_pipe_reg_sat_counter.sv | 36 +++
 rtl/if_id_pipe_reg.sv | 97 +++++++++
 tb/tb_if_id_pipe_reg.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/if_id_pipe_reg_pkg.sv
// ---------------------------------------------------------------------------
// if_id_pipe_reg_pkg
// Shared CPU constants used by the pipeline registers.
//   CPU_DATA_W    : datapath width (instruction and PC fields)
//   CPU_NOP_INSTR : bubble instruction (sll $0,$0,0), also used by the
//                   ID/EX flush logic
// ---------------------------------------------------------------------------
package if_id_pipe_reg_pkg;

    localparam int CPU_DATA_W = 32;

    localparam logic [CPU_DATA_W-1:0] CPU_NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/if_id_pipe_reg_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Event counter that saturates at all-ones instead of wrapping.
// Ports:
//   clk   : clock, rising-edge
//   rst   : asynchronous active-high reset, clears the count
//   inc   : count one event on this edge
//   clr   : synchronous clear, takes priority over inc
//   count : current count
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_p1;

    // -- count register --
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_p1 <= '0;
        end else if (clr) begin
            count_p1 <= '0;
        end else if (inc && (count_p1 != {CNT_W{1'b1}})) begin
            count_p1 <= count_p1 + 1'b1;
        end
    end

    assign count = count_p1;

endmodule

// File: rtl/if_id_pipe_reg.sv
// ---------------------------------------------------------------------------
// if_id_pipe_reg
// IF/ID pipeline register: captures the fetched instruction and its PC+4,
// holds on a load-use stall, inserts a bubble on a branch flush, and keeps
// saturating stall/flush event counters for performance debug.
// Ports:
//   clk_i       : clock, rising-edge
//   rst_i       : asynchronous active-high reset
//   IFIDwrite   : 0 = stall (hold pipeline fields)
//   flush_i     : replace captured instruction with a bubble (wins over stall)
//   valid_i     : fetch produced a real instruction
//   pc_plus4_i  : PC+4 from fetch
//   instr_i     : instruction from instruction memory
//   cnt_clr_i   : synchronous clear of both counters
//   pc_plus4_o  : registered PC+4
//   instr_o     : registered instruction (NOP whenever valid_o is 0)
//   valid_o     : decode-stage instruction is real
//   stall_cnt_o : cycles a valid instruction was held by a stall
//   flush_cnt_o : valid instructions discarded by a flush
// ---------------------------------------------------------------------------
module if_id_pipe_reg
    import if_id_pipe_reg_pkg::*;
#(
    parameter int                 DATA_W    = CPU_DATA_W,
    parameter logic [DATA_W-1:0]  NOP_INSTR = CPU_NOP_INSTR,
    parameter int                 CNT_W     = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              IFIDwrite,
    input  logic              flush_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] pc_plus4_i,
    input  logic [DATA_W-1:0] instr_i,
    input  logic              cnt_clr_i,
    output logic [DATA_W-1:0] pc_plus4_o,
    output logic [DATA_W-1:0] instr_o,
    output logic              valid_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    logic [DATA_W-1:0] pc_plus4_p1;
    logic [DATA_W-1:0] instr_p1;
    logic              vld_p1;

    logic stall_event;
    logic flush_event;

    // -- IF -> ID register --
    // Flush loads the new PC+4 even when the hazard unit asks for a stall,
    // so the bubble carries a coherent PC.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_plus4_p1 <= '0;
            instr_p1    <= NOP_INSTR;
            vld_p1      <= 1'b0;
        end else if (flush_i) begin
            pc_plus4_p1 <= pc_plus4_i;
            instr_p1    <= NOP_INSTR;
            vld_p1      <= 1'b0;
        end else if (IFIDwrite) begin
            pc_plus4_p1 <= pc_plus4_i;
            vld_p1      <= valid_i;
            instr_p1    <= valid_i ? instr_i : NOP_INSTR;
        end
    end

    assign pc_plus4_o = pc_plus4_p1;
    assign instr_o    = instr_p1;
    assign valid_o    = vld_p1;

    // Only real instructions count; holding or discarding a bubble is free.
    assign stall_event = !flush_i && !IFIDwrite && vld_p1;
    assign flush_event = flush_i && vld_p1;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk_i),
        .rst   (rst_i),
        .inc   (stall_event),
        .clr   (cnt_clr_i),
        .count (stall_cnt_o)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .clk   (clk_i),
        .rst   (rst_i),
        .inc   (flush_event),
        .clr   (cnt_clr_i),
        .count (flush_cnt_o)
    );

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Testbench for if_id_pipe_reg (CNT_W = 4 so saturation is reachable).
module tb_if_id_pipe_reg;

    localparam int DW = 32;
    localparam int CW = 4;
    localparam logic [DW-1:0] NOP = 32'h0000_0000;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          IFIDwrite = 1'b0;
    logic          flush_i = 1'b0;
    logic          valid_i = 1'b0;
    logic [DW-1:0] pc_plus4_i = '0;
    logic [DW-1:0] instr_i = '0;
    logic          cnt_clr_i = 1'b0;
    logic [DW-1:0] pc_plus4_o;
    logic [DW-1:0] instr_o;
    logic          valid_o;
    logic [CW-1:0] stall_cnt_o;
    logic [CW-1:0] flush_cnt_o;

    if_id_pipe_reg #(
        .DATA_W    (DW),
        .NOP_INSTR (NOP),
        .CNT_W     (CW)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .IFIDwrite   (IFIDwrite),
        .flush_i     (flush_i),
        .valid_i     (valid_i),
        .pc_plus4_i  (pc_plus4_i),
        .instr_i     (instr_i),
        .cnt_clr_i   (cnt_clr_i),
        .pc_plus4_o  (pc_plus4_o),
        .instr_o     (instr_o),
        .valid_o     (valid_o),
        .stall_cnt_o (stall_cnt_o),
        .flush_cnt_o (flush_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string         name;
        logic [DW-1:0] pc;
        logic [DW-1:0] instr;
        logic          vld;
        logic [CW-1:0] scnt;
        logic [CW-1:0] fcnt;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: one registered output set per clock edge, compared against
    // the oldest pending expectation.
    always @(posedge clk_i) begin
        #1;
        if (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            check({e.name, ".pc"},    pc_plus4_o,  e.pc);
            check({e.name, ".instr"}, instr_o,     e.instr);
            check({e.name, ".valid"}, 32'(valid_o),     32'(e.vld));
            check({e.name, ".stall"}, 32'(stall_cnt_o), 32'(e.scnt));
            check({e.name, ".flush"}, 32'(flush_cnt_o), 32'(e.fcnt));
        end
    end

    // Drive one cycle of inputs and queue the hand-computed result.
    task automatic step(input string name,
                        input logic ifw, input logic fl, input logic v, input logic clr,
                        input logic [DW-1:0] pc, input logic [DW-1:0] ins,
                        input logic [DW-1:0] e_pc, input logic [DW-1:0] e_ins,
                        input logic e_v, input logic [CW-1:0] e_s, input logic [CW-1:0] e_f);
        exp_t e;
        @(negedge clk_i);
        IFIDwrite  = ifw;
        flush_i    = fl;
        valid_i    = v;
        cnt_clr_i  = clr;
        pc_plus4_i = pc;
        instr_i    = ins;
        e.name = name; e.pc = e_pc; e.instr = e_ins; e.vld = e_v; e.scnt = e_s; e.fcnt = e_f;
        sbq.push_back(e);
        @(posedge clk_i);
    endtask

    task automatic check_reset_state(input string name);
        check({name, ".pc"},    pc_plus4_o, 32'h0);
        check({name, ".instr"}, instr_o,    NOP);
        check({name, ".valid"}, 32'(valid_o),     32'h0);
        check({name, ".stall"}, 32'(stall_cnt_o), 32'h0);
        check({name, ".flush"}, 32'(flush_cnt_o), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit, expected to finish");
        $fatal(1, "timeout");
    end

    initial begin
        int s;
        #1 rst_i = 1'b1;
        #1 check_reset_state("reset_init");
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;

        // name, ifw, fl, v, clr, pc, instr, exp pc, exp instr, exp v, exp stall, exp flush
        step("load",        1, 0, 1, 0, 32'h4,  32'h2008_0005, 32'h4,  32'h2008_0005, 1, 4'd0, 4'd0);
        step("stall1",      0, 0, 1, 0, 32'h8,  32'h0,         32'h4,  32'h2008_0005, 1, 4'd1, 4'd0);
        step("stall2",      0, 0, 1, 0, 32'h8,  32'h0,         32'h4,  32'h2008_0005, 1, 4'd2, 4'd0);
        step("stall3",      0, 0, 1, 0, 32'h8,  32'h0,         32'h4,  32'h2008_0005, 1, 4'd3, 4'd0);
        step("flush_stall", 0, 1, 1, 0, 32'hC,  32'h0000_1234, 32'hC,  NOP,           0, 4'd3, 4'd1);
        step("bubble_load", 1, 0, 0, 0, 32'h10, 32'hDEAD_BEEF, 32'h10, NOP,           0, 4'd3, 4'd1);
        step("bubble_stall",0, 0, 1, 0, 32'h14, 32'h1111_1111, 32'h10, NOP,           0, 4'd3, 4'd1);
        step("bubble_flush",1, 1, 1, 0, 32'h18, 32'h2222_2222, 32'h18, NOP,           0, 4'd3, 4'd1);
        step("load2",       1, 0, 1, 0, 32'h1C, 32'h8C22_0004, 32'h1C, 32'h8C22_0004, 1, 4'd3, 4'd1);
        step("flush_write", 1, 1, 1, 0, 32'h20, 32'hAC22_0008, 32'h20, NOP,           0, 4'd3, 4'd2);
        step("load3",       1, 0, 1, 0, 32'h24, 32'h0043_0820, 32'h24, 32'h0043_0820, 1, 4'd3, 4'd2);
        for (int i = 1; i <= 20; i++) begin
            s = (3 + i > 15) ? 15 : 3 + i;
            step("sat_stall", 0, 0, 1, 0, 32'h28, 32'h0, 32'h24, 32'h0043_0820, 1, CW'(s), 4'd2);
        end
        step("clr_stall",   0, 0, 1, 1, 32'h28, 32'h0, 32'h24, 32'h0043_0820, 1, 4'd0, 4'd0);
        step("post_clr",    0, 0, 1, 0, 32'h28, 32'h0, 32'h24, 32'h0043_0820, 1, 4'd1, 4'd0);
        step("clr_flush",   0, 1, 1, 1, 32'h2C, 32'h0, 32'h2C, NOP,           0, 4'd0, 4'd0);
        step("load4",       1, 0, 1, 0, 32'h30, 32'h2009_0007, 32'h30, 32'h2009_0007, 1, 4'd0, 4'd0);
        step("stall_pre",   0, 0, 1, 0, 32'h34, 32'h0, 32'h30, 32'h2009_0007, 1, 4'd1, 4'd0);

        // Asynchronous reset mid-cycle while a stall is being requested.
        @(negedge clk_i);
        #2 rst_i = 1'b1;
        #1 check_reset_state("reset_async");
        @(posedge clk_i);
        #1 check_reset_state("reset_held");
        @(negedge clk_i);
        rst_i = 1'b0;
        step("load_after_rst", 1, 0, 1, 0, 32'h38, 32'h2009_0007, 32'h38, 32'h2009_0007, 1, 4'd0, 4'd0);

        for (int i = 0; i < 5 && sbq.size() > 0; i++) @(posedge clk_i);
        #2;
        n_checks++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations pending, expected 0", sbq.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
